// File: rtl/md_sched.sv
// Multiply/divide scheduler beside the E-stage ALU: owns HI/LO and models
// fixed-latency mult/div occupancy. Define MD_SCHED_MADD_EN to add madd/maddu/msub/msubu.
module md_sched #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_SCHED_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  logic        busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;

  logic [63:0] rs_sx, rt_sx, prod_s, prod_u;
  logic        rt_zero;
  logic [31:0] den_u, divu_q, divu_r;
  logic [31:0] rs_abs, rt_abs, den_s, q_abs, r_abs, div_q, div_r;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign rs_sx  = {{32{rs_val[31]}}, rs_val};
  assign rt_sx  = {{32{rt_val[31]}}, rt_val};
  assign prod_s = rs_sx * rt_sx;
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed division on magnitudes; 0x80000000 / -1 then naturally yields 0x80000000 rem 0.
  assign rt_zero = (rt_val == 32'd0);
  assign den_u   = rt_zero ? 32'd1 : rt_val;
  assign divu_q  = rs_val / den_u;
  assign divu_r  = rs_val % den_u;
  assign rs_abs  = rs_val[31] ? -rs_val : rs_val;
  assign rt_abs  = rt_val[31] ? -rt_val : rt_val;
  assign den_s   = rt_zero ? 32'd1 : rt_abs;
  assign q_abs   = rs_abs / den_s;
  assign r_abs   = rs_abs % den_s;
  assign div_q   = (rs_val[31] ^ rt_val[31]) ? -q_abs : q_abs;
  assign div_r   = rs_val[31] ? -r_abs : r_abs;

`ifdef MD_SCHED_MADD_EN
  logic [63:0] acc_base;
  assign acc_base = {hi_q, lo_q};
`endif

  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    if (busy_q) begin
      // Any start while busy is dropped so the in-flight op stays intact.
      cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
      if (cnt_q <= 4'd1) begin
        busy_d    = 1'b0;
        pend_wr_d = 1'b0;
        if (pend_wr_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
    end else if (start) begin
      case (md_op)
        OP_MULT: begin
          {pend_hi_d, pend_lo_d} = prod_s;
          pend_wr_d = 1'b1;
          cnt_d     = MULT_CNT;
          busy_d    = 1'b1;
        end
        OP_MULTU: begin
          {pend_hi_d, pend_lo_d} = prod_u;
          pend_wr_d = 1'b1;
          cnt_d     = MULT_CNT;
          busy_d    = 1'b1;
        end
        OP_DIV: begin
          pend_hi_d = div_r;
          pend_lo_d = div_q;
          pend_wr_d = !rt_zero;
          cnt_d     = DIV_CNT;
          busy_d    = 1'b1;
        end
        OP_DIVU: begin
          pend_hi_d = divu_r;
          pend_lo_d = divu_q;
          pend_wr_d = !rt_zero;
          cnt_d     = DIV_CNT;
          busy_d    = 1'b1;
        end
        OP_MTHI: hi_d = rs_val;
        OP_MTLO: lo_d = rs_val;
`ifdef MD_SCHED_MADD_EN
        OP_MADD: begin
          {pend_hi_d, pend_lo_d} = acc_base + prod_s;
          pend_wr_d = 1'b1;
          cnt_d     = MULT_CNT;
          busy_d    = 1'b1;
        end
        OP_MADDU: begin
          {pend_hi_d, pend_lo_d} = acc_base + prod_u;
          pend_wr_d = 1'b1;
          cnt_d     = MULT_CNT;
          busy_d    = 1'b1;
        end
        OP_MSUB: begin
          {pend_hi_d, pend_lo_d} = acc_base - prod_s;
          pend_wr_d = 1'b1;
          cnt_d     = MULT_CNT;
          busy_d    = 1'b1;
        end
        OP_MSUBU: begin
          {pend_hi_d, pend_lo_d} = acc_base - prod_u;
          pend_wr_d = 1'b1;
          cnt_d     = MULT_CNT;
          busy_d    = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q    <= 1'b0;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy     = busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign md_stall = d_is_md & (busy_q | start);

endmodule

// File: tb/tb_md_sched.sv
// Directed scoreboard bench for md_sched: expected HI/LO pushed at issue,
// popped and compared when busy falls.
module tb_md_sched;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_is_md;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  md_sched dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .d_is_md  (d_is_md),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    step();
    start  = 1'b0;
    md_op  = 4'd0;
  endtask

  // Issue a long op, measure the busy window and compare the committed result.
  task automatic run_long(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic stall_chk);
    exp_t        e;
    int          bn;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    old_hi = hi;
    old_lo = lo;
    e.hi = ehi;
    e.lo = elo;
    sb.push_back(e);
    d_is_md = stall_chk;
    start   = 1'b1;
    md_op   = op;
    rs_val  = a;
    rt_val  = b;
    #1;
    if (stall_chk) check_output({tag, "_stall_issue"}, 64'(md_stall), 64'd1);
    step();
    start = 1'b0;
    md_op = 4'd0;
    bn = 0;
    while (busy === 1'b1 && bn < 40) begin
      bn++;
      if (bn == 1) check_output({tag, "_no_pending_vis"}, {hi, lo}, {old_hi, old_lo});
      if (stall_chk) check_output({tag, "_stall_busy"}, 64'(md_stall), 64'd1);
      step();
    end
    check_output({tag, "_busy_len"}, 64'(bn), 64'(lat));
    e = sb.pop_front();
    check_output({tag, "_hi"}, 64'(hi), 64'(e.hi));
    check_output({tag, "_lo"}, 64'(lo), 64'(e.lo));
    if (stall_chk) check_output({tag, "_stall_after"}, 64'(md_stall), 64'd0);
    d_is_md = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g;
    reset   = 1'b1;
    start   = 1'b0;
    md_op   = 4'd0;
    rs_val  = 32'd0;
    rt_val  = 32'd0;
    d_is_md = 1'b0;
    #1;
    check_output("reset_busy", 64'(busy), 64'd0);
    check_output("reset_hilo", {hi, lo}, 64'd0);
    check_output("reset_stall", 64'(md_stall), 64'd0);
    step();
    step();
    reset = 1'b0;
    step();

    apply_stimulus(4'd5, 32'haa, 32'd0);
    apply_stimulus(4'd6, 32'hbb, 32'd0);
    check_output("preload_hilo", {hi, lo}, {32'haa, 32'hbb});

    // Asynchronous reset in the middle of a divide discards the pending result.
    apply_stimulus(4'd3, 32'd7, 32'd2);
    step();
    check_output("middiv_busy", 64'(busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_output("middiv_rst_busy", 64'(busy), 64'd0);
    check_output("middiv_rst_hilo", {hi, lo}, 64'd0);
    #3;
    reset = 1'b0;
    step();
    repeat (12) step();
    check_output("middiv_no_commit_busy", 64'(busy), 64'd0);
    check_output("middiv_no_commit_hilo", {hi, lo}, 64'd0);

    run_long("mult",       4'd1, 32'hfffffffd, 32'd5,        5,  32'hffffffff, 32'hfffffff1, 1'b1);
    run_long("multu",      4'd2, 32'hffffffff, 32'd2,        5,  32'h1,        32'hfffffffe, 1'b0);
    run_long("div_neg",    4'd3, 32'hfffffff9, 32'd2,        10, 32'hffffffff, 32'hfffffffd, 1'b0);
    run_long("div_ovf",    4'd3, 32'h80000000, 32'hffffffff, 10, 32'h0,        32'h80000000, 1'b0);
    run_long("div_negden", 4'd3, 32'd7,        32'hfffffffe, 10, 32'h1,        32'hfffffffd, 1'b0);
    apply_stimulus(4'd5, 32'h11, 32'd0);
    apply_stimulus(4'd6, 32'h22, 32'd0);
    run_long("divu_zero",  4'd4, 32'd7,        32'd0,        10, 32'h11,       32'h22,       1'b0);
    run_long("divu",       4'd4, 32'd100,      32'd7,        10, 32'd2,        32'd14,       1'b0);

    // A start arriving while busy must be dropped.
    apply_stimulus(4'd1, 32'd3, 32'd4);
    step();
    apply_stimulus(4'd6, 32'h1234, 32'd0);
    check_output("ignored_busy", 64'(busy), 64'd1);
    check_output("ignored_lo_mid", 64'(lo), 64'd14);
    g = 0;
    while (busy === 1'b1 && g < 40) begin
      g++;
      step();
    end
    check_output("ignored_tail_len", 64'(g), 64'd3);
    check_output("ignored_hilo", {hi, lo}, {32'd0, 32'hc});
    step();
    check_output("ignored_late_lo", 64'(lo), 64'hc);

    apply_stimulus(4'd5, 32'hdeadbeef, 32'd0);
    check_output("mthi_hi", 64'(hi), 64'hdeadbeef);
    check_output("mthi_busy", 64'(busy), 64'd0);

    start   = 1'b1;
    md_op   = 4'd6;
    rs_val  = 32'h55;
    d_is_md = 1'b1;
    #1;
    check_output("same_cycle_stall", 64'(md_stall), 64'd1);
    step();
    start   = 1'b0;
    md_op   = 4'd0;
    #1;
    check_output("mtlo_stall_low", 64'(md_stall), 64'd0);
    check_output("mtlo_lo", 64'(lo), 64'h55);
    d_is_md = 1'b0;

    apply_stimulus(4'd5, 32'd0, 32'd0);
    apply_stimulus(4'd6, 32'hffffffff, 32'd0);
`ifdef MD_SCHED_MADD_EN
    run_long("madd", 4'd7, 32'd1, 32'd1, 5, 32'd1, 32'd0, 1'b0);
`else
    apply_stimulus(4'd7, 32'd1, 32'd1);
    check_output("madd_off_busy", 64'(busy), 64'd0);
    repeat (6) step();
    check_output("madd_off_busy_late", 64'(busy), 64'd0);
    check_output("madd_off_hilo", {hi, lo}, {32'd0, 32'hffffffff});
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
